fpcvt_pipe: RTL

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

---
 rtl/fpcvt_pkg.sv | 29 ++
 rtl/fpcvt_lzc.sv | 18 +
 rtl/fpcvt_pipe.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: shared constants for the fixed-to-float converter pipe.
// Rounding-mode encodings and default widths live here.
package fpcvt_pkg;

    localparam logic [1:0] RM_TRUNC  = 2'b00;
    localparam logic [1:0] RM_HALFUP = 2'b01;
    localparam logic [1:0] RM_RNE    = 2'b10;

    localparam int IN_W_DEF  = 12;
    localparam int EXP_W_DEF = 3;
    localparam int MAN_W_DEF = 4;

    // Reserved mode 11 rounds like half-up.
    function automatic logic rnd_inc(
        input logic [1:0] rm,
        input logic       r,
        input logic       t,
        input logic       lsb
    );
        logic inc;
        unique case (1'b1)
            (rm == RM_TRUNC): inc = 1'b0;
            (rm == RM_RNE):   inc = r & (t | lsb);
            default:          inc = r;
        endcase
        return inc;
    endfunction

endpackage

// File: rtl/fpcvt_lzc.sv
// fpcvt_lzc: combinational leading-zero count over a W-bit word.
// An all-zero word yields W.
module fpcvt_lzc #(
    parameter  int W  = 12,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a_i,
    output logic [CW-1:0] cnt_o
);

    always_comb begin
        cnt_o = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (a_i[i]) cnt_o = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/fpcvt_pipe.sv
// fpcvt_pipe: 3-stage two's-complement to sign/exponent/significand
// converter with valid/ready flow control and selectable rounding.
module fpcvt_pipe
    import fpcvt_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int MAN_W = MAN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  D,
    input  logic [1:0]       rmode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [MAN_W-1:0] F,
    output logic             sat,
    output logic             inexact
);

    localparam int LZW = $clog2(IN_W + 1);
    localparam int OFS = IN_W - MAN_W;
    localparam logic [IN_W-1:0] MIN_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0] MAX_MAG = {1'b0, {(IN_W-1){1'b1}}};

    if (IN_W < MAN_W + 2 || IN_W > MAN_W + (1 << EXP_W)) begin : g_bad_params
        $error("fpcvt_pipe: illegal IN_W/EXP_W/MAN_W combination");
    end

    logic s1_v_q, s2_v_q, s3_v_q;
    logic ld1, ld2, ld3;

    assign ld3      = !s3_v_q || out_ready;
    assign ld2      = !s2_v_q || ld3;
    assign ld1      = !s1_v_q || ld2;
    assign in_ready = ld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
        end else begin
            if (ld1) s1_v_q <= in_valid;
            if (ld2) s2_v_q <= s1_v_q;
            if (ld3) s3_v_q <= s2_v_q;
        end
    end

    // S1: sign/magnitude, clamping the most negative input.
    logic            s1_s_d, s1_sat_d;
    logic [IN_W-1:0] s1_m_d;
    logic            s1_s_q, s1_sat_q;
    logic [IN_W-1:0] s1_m_q;
    logic [1:0]      s1_rm_q;

    always_comb begin
        s1_s_d   = D[IN_W-1];
        s1_sat_d = (D == MIN_NEG);
        s1_m_d   = s1_s_d ? (~D + IN_W'(1)) : D;
        if (s1_sat_d) s1_m_d = MAX_MAG;
    end

    always_ff @(posedge clk) begin
        if (ld1 && in_valid) begin
            s1_s_q   <= s1_s_d;
            s1_sat_q <= s1_sat_d;
            s1_m_q   <= s1_m_d;
            s1_rm_q  <= rmode;
        end
    end

    // S2: normalise, extract significand, round and sticky bits.
    logic [LZW-1:0]   lz;
    int               e0;
    logic [EXP_W-1:0] s2_e0_d;
    logic [MAN_W-1:0] s2_f0_d;
    logic             s2_r_d, s2_t_d;
    logic             s2_s_q, s2_sat_q, s2_r_q, s2_t_q;
    logic [EXP_W-1:0] s2_e0_q;
    logic [MAN_W-1:0] s2_f0_q;
    logic [1:0]       s2_rm_q;

    fpcvt_lzc #(.W(IN_W)) u_lzc (
        .a_i   (s1_m_q),
        .cnt_o (lz)
    );

    always_comb begin
        e0 = 0;
        if (int'(lz) < OFS) e0 = OFS - int'(lz);
        s2_f0_d = MAN_W'(s1_m_q >> e0);
        s2_r_d  = 1'b0;
        s2_t_d  = 1'b0;
        for (int j = 0; j < IN_W; j++) begin
            if (j == e0 - 1) s2_r_d = s1_m_q[j];
            if (j < e0 - 1)  s2_t_d = s2_t_d | s1_m_q[j];
        end
        s2_e0_d = EXP_W'(e0);
    end

    always_ff @(posedge clk) begin
        if (ld2 && s1_v_q) begin
            s2_s_q   <= s1_s_q;
            s2_sat_q <= s1_sat_q;
            s2_rm_q  <= s1_rm_q;
            s2_e0_q  <= s2_e0_d;
            s2_f0_q  <= s2_f0_d;
            s2_r_q   <= s2_r_d;
            s2_t_q   <= s2_t_d;
        end
    end

    // S3: round, renormalise on carry, saturate at max exponent.
    logic             inc;
    logic [MAN_W:0]   sum;
    logic [EXP_W-1:0] e_d;
    logic [MAN_W-1:0] f_d;
    logic             sat_d, inx_d;
    logic             s_q, sat_q, inx_q;
    logic [EXP_W-1:0] e_q;
    logic [MAN_W-1:0] f_q;

    always_comb begin
        inc   = rnd_inc(s2_rm_q, s2_r_q, s2_t_q, s2_f0_q[0]);
        sum   = {1'b0, s2_f0_q} + (MAN_W+1)'(inc);
        e_d   = s2_e0_q;
        f_d   = sum[MAN_W-1:0];
        sat_d = s2_sat_q;
        if (sum[MAN_W]) begin
            if (&s2_e0_q) begin
                e_d   = '1;
                f_d   = '1;
                sat_d = 1'b1;
            end else begin
                e_d = s2_e0_q + EXP_W'(1);
                f_d = {1'b1, {(MAN_W-1){1'b0}}};
            end
        end
        inx_d = s2_r_q | s2_t_q | sat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q   <= 1'b0;
            e_q   <= '0;
            f_q   <= '0;
            sat_q <= 1'b0;
            inx_q <= 1'b0;
        end else if (ld3 && s2_v_q) begin
            s_q   <= s2_s_q;
            e_q   <= e_d;
            f_q   <= f_d;
            sat_q <= sat_d;
            inx_q <= inx_d;
        end
    end

    assign out_valid = s3_v_q;
    assign S         = s_q;
    assign E         = e_q;
    assign F         = f_q;
    assign sat       = sat_q;
    assign inexact   = inx_q;

endmodule
